// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that shares one byte-wide UART transmitter
// between NUM_REQ requesters. A message is never interleaved with another requester's bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                          CLK100MHZ,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic                          lock_drop,
    output logic [1:0]                    state_dbg
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, HOLD = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              last_grant_q;
    logic                    last_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    win_found;
    logic [2:0]              win_idx;
    logic [2:0]              sel_idx;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;
    logic                    owner_valid;
    logic                    accept;
    logic                    timeout;

    assign state_dbg = state_q;

    // Round-robin search: the first valid requester after last_grant_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!win_found && req_valid[k] && (k == (int'(last_grant_q) + i) % NUM_REQ)) begin
                    win_found = 1'b1;
                    win_idx   = 3'(k);
                end
            end
        end
    end

    // In HOLD only the lock owner may be selected; in IDLE the round-robin winner.
    always_comb begin
        sel_idx     = (state_q == HOLD) ? grant_id : win_idx;
        sel_onehot  = '0;
        sel_data    = '0;
        sel_last    = 1'b0;
        owner_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == int'(sel_idx)) begin
                sel_onehot[k] = 1'b1;
                sel_data      = req_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_last      = req_last[k];
            end
            if (k == int'(grant_id)) begin
                owner_valid = req_valid[k];
            end
        end
    end

    // Handshake: a byte moves on a rising edge where req_valid[k] and req_ready[k]
    // are both high; req_ready is combinational and never depends on tx_done.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready = sel_onehot;
                    accept    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = last_q ? IDLE : HOLD;
            end
            HOLD: begin
                if (owner_valid) begin
                    req_ready = sel_onehot;
                    accept    = 1'b1;
                    state_d   = SEND;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            tx_en        <= 1'b0;
            tx_data      <= '0;
            grant_id     <= 3'd0;
            busy         <= 1'b0;
            lock_drop    <= 1'b0;
            last_grant_q <= 3'(NUM_REQ - 1);
            last_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            lock_drop <= 1'b0;
            if (accept) begin
                tx_data  <= sel_data;
                tx_en    <= 1'b1;
                last_q   <= sel_last;
                grant_id <= sel_idx;
                busy     <= 1'b1;
            end
            if (state_q == SEND && tx_done) begin
                tx_en <= 1'b0;
            end
            if (state_q == GAP) begin
                if (last_q) begin
                    busy         <= 1'b0;
                    last_grant_q <= grant_id;
                end else begin
                    cnt_q <= '0;
                end
            end
            if (state_q == HOLD && !accept) begin
                if (timeout) begin
                    lock_drop    <= 1'b1;
                    busy         <= 1'b0;
                    last_grant_q <= grant_id;
                end else if (cnt_q != CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, locked messages, fairness,
// lock timeout, stray tx_done and mid-frame reset.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int LT      = 16;

    logic                   clk;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_en;
    logic [DW-1:0]          tx_data;
    logic                   tx_done;
    logic [2:0]             grant_id;
    logic                   busy;
    logic                   lock_drop;
    logic [1:0]             state_dbg;

    int checks;
    int failures;

    // Per-requester stimulus queues: {last, byte}. Scoreboard entries: {grant, byte}.
    logic [8:0]  rq [NUM_REQ][$];
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
    ) dut (
        .CLK100MHZ(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
        .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .lock_drop(lock_drop),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) rq[k].delete();
        exp_q.delete();
        got_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- driver: requesters + transmitter model ----------------
    task automatic run_traffic(input int n_frames);
        int frames = 0;
        int cyc = 0;
        int hold = 0;
        logic in_frame = 1'b0;
        logic [NUM_REQ-1:0] acc = '0;
        while (frames < n_frames && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            if (tx_done) begin
                tx_done = 1'b0;
            end else if (tx_en && !in_frame) begin
                in_frame = 1'b1;
                hold = 0;
                got_q.push_back({grant_id, tx_data});
            end else if (in_frame) begin
                hold++;
                if (hold == 2) begin
                    tx_done = 1'b1;
                    in_frame = 1'b0;
                    frames++;
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                req_valid[k] = (rq[k].size() > 0);
                if (rq[k].size() > 0) begin
                    req_data[k*DW +: DW] = rq[k][0][7:0];
                    req_last[k] = rq[k][0][8];
                end
            end
            #1;
            acc = req_valid & req_ready;
        end
        checks++;
        if (frames != n_frames) begin
            failures++;
            $display("FAIL traffic_frames: got %0d frames, expected %0d", frames, n_frames);
        end
        @(negedge clk);
        tx_done = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 4'hF;
        req_data = '0;
        req_last = '0;
        tx_done = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en: got %0b expected 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
        checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (lock_drop !== 1'b0) begin failures++; $display("FAIL reset_lock_drop: got %0b expected 0", lock_drop); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        req_valid = 4'b1010;
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL reset_first_prio: got %b expected 0010", req_ready); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_data[15:8] = 8'hA1;
        req_last[1] = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (tx_en !== 1'b1) begin failures++; $display("FAIL single_tx_en: got %0b expected 1", tx_en); end
        checks++; if (tx_data !== 8'hA1) begin failures++; $display("FAIL single_tx_data: got %0h expected a1", tx_data); end
        checks++; if (grant_id !== 3'd1) begin failures++; $display("FAIL single_grant: got %0d expected 1", grant_id); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b expected 1", busy); end
        @(negedge clk);
        checks++; if (tx_en !== 1'b1 || tx_data !== 8'hA1) begin failures++; $display("FAIL single_hold: got en=%0b data=%0h expected en=1 data=a1", tx_en, tx_data); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL single_gap_tx_en: got %0b expected 0", tx_en); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_gap_busy: got %0b expected 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_two_msgs();
        logic [10:0] exp_v, got_v;
        do_reset();
        rq[0].push_back({1'b0, 8'hB2});
        rq[0].push_back({1'b1, 8'hC3});
        rq[2].push_back({1'b0, 8'hD4});
        rq[2].push_back({1'b1, 8'hE5});
        exp_q.push_back({3'd0, 8'hB2});
        exp_q.push_back({3'd0, 8'hC3});
        exp_q.push_back({3'd2, 8'hD4});
        exp_q.push_back({3'd2, 8'hE5});
        run_traffic(4);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL two_msgs_order: got grant=%0d byte=%0h expected grant=%0d byte=%0h",
                         got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [10:0] exp_v, got_v;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rq[k].push_back({1'b1, 8'(8'h40 + 8'h10 * r + k)});
                exp_q.push_back({3'(k), 8'(8'h40 + 8'h10 * r + k)});
            end
        end
        run_traffic(8);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL fairness_order: got grant=%0d byte=%0h expected grant=%0d byte=%0h",
                         got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
            end
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000;
        req_data[31:24] = 8'h11;
        req_last[3] = 1'b0;
        @(negedge clk);
        req_valid = 4'b0001;
        req_data[7:0] = 8'h22;
        req_last[0] = 1'b1;
        #1;
        checks++; if (grant_id !== 3'd3 || tx_data !== 8'h11) begin failures++; $display("FAIL timeout_first: got grant=%0d data=%0h expected grant=3 data=11", grant_id, tx_data); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL timeout_send_ready: got %b expected 0000", req_ready); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++; if (tx_en !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_gap: got en=%0b busy=%0b expected en=0 busy=1", tx_en, busy); end
        for (int i = 0; i < LT; i++) begin
            @(negedge clk);
            if (lock_drop !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL timeout_hold: got %0d bad HOLD cycles expected 0", bad); end
        @(negedge clk);
        checks++; if (lock_drop !== 1'b1) begin failures++; $display("FAIL timeout_lock_drop: got %0b expected 1", lock_drop); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %0b expected 0", busy); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL timeout_next_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (lock_drop !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: got %0b expected 0", lock_drop); end
        checks++; if (grant_id !== 3'd0 || tx_data !== 8'h22 || tx_en !== 1'b1) begin failures++; $display("FAIL timeout_next_grant: got grant=%0d data=%0h en=%0b expected grant=0 data=22 en=1", grant_id, tx_data, tx_en); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_end_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_stray_done();
        do_reset();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++; if (state_dbg !== 2'd0 || busy !== 1'b0 || tx_en !== 1'b0) begin failures++; $display("FAIL stray_idle: got state=%0d busy=%0b en=%0b expected 0/0/0", state_dbg, busy, tx_en); end
        req_valid = 4'b0010;
        req_data[15:8] = 8'h5A;
        req_last[1] = 1'b1;
        @(negedge clk);
        req_valid = '0;
        checks++; if (tx_en !== 1'b1 || tx_data !== 8'h5A) begin failures++; $display("FAIL stray_send: got en=%0b data=%0h expected en=1 data=5a", tx_en, tx_data); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        checks++; if (tx_en !== 1'b0 || state_dbg !== 2'd2) begin failures++; $display("FAIL stray_gap: got en=%0b state=%0d expected en=0 state=2", tx_en, state_dbg); end
        @(negedge clk);
        checks++; if (state_dbg !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL stray_gap_len: got state=%0d busy=%0b expected state=0 busy=0", state_dbg, busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        req_data[23:16] = 8'h77;
        req_last[2] = 1'b0;
        @(negedge clk);
        checks++; if (tx_en !== 1'b1 || grant_id !== 3'd2) begin failures++; $display("FAIL mid_send: got en=%0b grant=%0d expected en=1 grant=2", tx_en, grant_id); end
        req_valid = 4'b0101;
        req_data[7:0] = 8'h33;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (tx_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async: got en=%0b busy=%0b expected 0/0", tx_en, busy); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready: got %b expected 0000", req_ready); end
        checks++; if (grant_id !== 3'd0 || tx_data !== 8'h00) begin failures++; $display("FAIL mid_regs: got grant=%0d data=%0h expected 0/0", grant_id, tx_data); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_priority: got %b expected 0001", req_ready); end
        req_valid = '0;
        @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_two_msgs();
        test_fairness();
        test_timeout();
        test_stray_done();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
